// File: rtl/seq_divider.sv
// seq_divider
//    Multi-cycle radix-2 restoring divider for DIV/DIVU. One trial subtract per
//    cycle over WIDTH iterations, followed by one sign-correction cycle.
//    Results feed HI (remainder) and LO (quotient).
//
// Ports
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    start      request pulse, honoured only when no operation is in flight
//    is_signed  1 = two's complement divide, 0 = unsigned divide
//    dividend   numerator, sampled with start
//    divisor    denominator, sampled with start
//    busy       high while an operation is in flight
//    done       one-cycle pulse when quotient/remainder/div_zero are valid
//    quotient   registered quotient
//    remainder  registered remainder
//    div_zero   registered flag, last operation had a zero divisor

module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [CNT_W-1:0] count;
   logic             sign_q;
   logic             sign_r;
   logic             zero_q;

   logic             load;
   logic             last_iter;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;

   // A new operation is accepted from IDLE and also from DONE, so a start
   // presented in the done cycle runs back-to-back without a dead cycle.
   assign load      = start && ((state == IDLE) || (state == DONE));
   assign last_iter = (count == CNT_W'(WIDTH - 1));

   // Magnitudes are taken as WIDTH-bit unsigned values, so the most-negative
   // number maps to 2^(WIDTH-1) without needing an extra bit.
   assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
   assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

   // The next dividend bit comes from the top of quo as {rem, quo} shifts left.
   // The trial subtract is add-the-inverse with carry-in; its top bit is the sign.
   assign rem_shift = {rem, quo[WIDTH-1]};
   assign trial     = rem_shift + {1'b1, ~dvsr} + {{WIDTH{1'b0}}, 1'b1};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ITER;
         ITER:    if (last_iter) next_state = FIX;
         FIX:     next_state = DONE;
         DONE:    next_state = start ? ITER : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ITER, FIX: busy = 1'b1;
         DONE:      done = 1'b1;
         default:   ;
      endcase
   end

   // Datapath. With a zero divisor every trial succeeds, so quo ends all ones
   // and rem ends holding |dividend|; sign-correcting rem then reproduces the
   // original dividend, which is exactly the divide-by-zero remainder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         zero_q    <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else if (load) begin
         rem    <= '0;
         quo    <= dividend_mag;
         dvsr   <= divisor_mag;
         count  <= '0;
         sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         sign_r <= is_signed & dividend[WIDTH-1];
         zero_q <= (divisor == '0);
      end else if (state == ITER) begin
         count <= count + 1'b1;
         rem   <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
         quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      end else if (state == FIX) begin
         div_zero  <= zero_q;
         quotient  <= zero_q ? '1 : (sign_q ? (~quo + 1'b1) : quo);
         remainder <= sign_r ? (~rem + 1'b1) : rem;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//    Directed bench for seq_divider. A reference model derives each result
//    from integer arithmetic and presents it a fixed number of edges after an
//    accepted start; a compare process checks every output on every falling
//    edge. Literal expectations after each operation pin the model itself.

module tb_seq_divider;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } result_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int          nChecks = 0;
   int          nPassed = 0;
   int          lat;

   // Model state: edges left until the pending result is presented.
   int          edgesLeft = 0;
   result_t     pendRes = '0;
   logic        expBusy = 1'b0;
   logic        expDone = 1'b0;
   logic [31:0] expQ = '0;
   logic [31:0] expR = '0;
   logic        expZ = 1'b0;

   seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   // Reference divide: truncating integer division on 64-bit values, which
   // also gives the remainder the sign of the dividend and wraps the
   // most-negative / -1 case back to most-negative on truncation.
   function automatic result_t refDivide(input logic s, input logic [31:0] a, input logic [31:0] b);
      result_t res;
      longint  sa;
      longint  sb;
      if (b == 32'd0) begin
         res.q = '1;
         res.r = a;
         res.z = 1'b1;
      end else begin
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end
         res.q = 32'(sa / sb);
         res.r = 32'(sa % sb);
         res.z = 1'b0;
      end
      return res;
   endfunction

   // Timeline model: an accepted start yields busy for 33 cycles, then the
   // result with a one-cycle done; a start is accepted whenever nothing is
   // pending, including the done cycle itself.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edgesLeft <= 0;
         expBusy   <= 1'b0;
         expDone   <= 1'b0;
         expQ      <= '0;
         expR      <= '0;
         expZ      <= 1'b0;
      end else if (edgesLeft > 0) begin
         edgesLeft <= edgesLeft - 1;
         if (edgesLeft == 1) begin
            expQ    <= pendRes.q;
            expR    <= pendRes.r;
            expZ    <= pendRes.z;
            expBusy <= 1'b0;
            expDone <= 1'b1;
         end
      end else begin
         expDone <= 1'b0;
         if (start) begin
            pendRes   <= refDivide(is_signed, dividend, divisor);
            edgesLeft <= 33;
            expBusy   <= 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("quotient", quotient, expQ);
      checkOutput("remainder", remainder, expR);
      checkOutput("div_zero", {31'd0, div_zero}, {31'd0, expZ});
   end

   // Drives a start pulse from the current (falling-edge) time, then scrambles
   // the operands once the request has been taken.
   task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
      is_signed = s;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      is_signed = ~s;
      dividend  = ~a;
      divisor   = b + 32'd1;
   endtask

   task automatic waitDone(output int waited);
      waited = 0;
      while (!done && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!done) checkOutput("doneTimeout", 32'd0, 32'd1);
   endtask

   task automatic checkResult(input string name, input logic [31:0] q, input logic [31:0] r, input logic z);
      checkOutput({name, ".q"}, quotient, q);
      checkOutput({name, ".r"}, remainder, r);
      checkOutput({name, ".z"}, {31'd0, div_zero}, {31'd0, z});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      checkResult("reset", 32'd0, 32'd0, 1'b0);
      rst_n = 1'b1;

      // 100/7 with a second start at E5 that must be ignored.
      applyStimulus(1'b0, 32'd100, 32'd7);
      repeat (4) @(negedge clk);
      is_signed = 1'b1;
      dividend  = 32'd55;
      divisor   = 32'd5;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      waitDone(lat);
      checkOutput("lat100div7", lat + 5, 32'd33);
      checkResult("u100div7", 32'd14, 32'd2, 1'b0);

      @(negedge clk);
      applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
      waitDone(lat);
      checkResult("sNeg7div2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

      // Back-to-back: started in the done cycle.
      applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
      waitDone(lat);
      checkOutput("latBackToBack", lat, 32'd33);
      checkResult("s7divNeg2", 32'hFFFF_FFFD, 32'd1, 1'b0);

      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(lat);
      checkResult("sOverflow", 32'h8000_0000, 32'd0, 1'b0);

      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
      waitDone(lat);
      checkResult("uMaxdiv1", 32'hFFFF_FFFF, 32'd0, 1'b0);

      @(negedge clk);
      applyStimulus(1'b1, 32'd5, 32'd0);
      waitDone(lat);
      checkOutput("latDivZero", lat, 32'd33);
      checkResult("s5div0", 32'hFFFF_FFFF, 32'd5, 1'b1);

      applyStimulus(1'b0, 32'd5, 32'd0);
      waitDone(lat);
      checkResult("u5div0", 32'hFFFF_FFFF, 32'd5, 1'b1);

      @(negedge clk);
      applyStimulus(1'b0, 32'd9, 32'd3);
      waitDone(lat);
      checkResult("u9div3", 32'd3, 32'd0, 1'b0);

      applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
      waitDone(lat);
      checkResult("sNeg100div7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

      applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
      waitDone(lat);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      applyStimulus(1'b0, 32'd50, 32'd3);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abortBusy", {31'd0, busy}, 32'd0);
      checkOutput("abortDone", {31'd0, done}, 32'd0);
      checkResult("abort", 32'd0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 32'd20, 32'd6);
      waitDone(lat);
      checkOutput("latAfterReset", lat, 32'd33);
      checkResult("u20div6", 32'd3, 32'd2, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
